// File: rtl/gen_clk_pkg.sv
// Shared types and constants for the programmable clock-divider bank.
package gen_clk_pkg;

  localparam int unsigned GEN_CLK_DEFAULT_DIV = 1000;

  typedef enum logic [1:0] {
    PARKED = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2
  } ch_state_e;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gen_clk_bank_if.sv
// Configuration/control and divided-clock outputs of the divider bank.
interface gen_clk_bank_if
  import gen_clk_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 12
);
  localparam int CH_W = ch_w(NUM_CH);

  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [DIV_W-1:0]     cfg_div;
  logic [NUM_CH-1:0]    ch_en;
  logic                 sync;
  logic [NUM_CH-1:0]    clk_out;
  logic [NUM_CH-1:0]    rise_stb;
  logic [NUM_CH-1:0]    fall_stb;
  logic [NUM_CH-1:0]    pending;

  modport master (
    output cfg_we, cfg_ch, cfg_div, ch_en, sync,
    input  clk_out, rise_stb, fall_stb, pending
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, ch_en, sync,
    output clk_out, rise_stb, fall_stb, pending
  );
endinterface

// File: rtl/gen_clk_chan.sv
// One divider channel: half-period counter, shadow/active divisor and run/drain/park FSM.
module gen_clk_chan
  import gen_clk_pkg::*;
#(
  parameter int          DIV_W       = 12,
  parameter int unsigned DEFAULT_DIV = GEN_CLK_DEFAULT_DIV
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             we,
  input  logic [DIV_W-1:0] wdiv,
  input  logic             en,
  input  logic             sync,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             pending
);
  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
  logic             pend_q, pend_d, clk_q, clk_d, rise_q, rise_d, fall_q, fall_d;
  logic             parked, sync_hit, count, tgl, xfer;
  logic [DIV_W-1:0] div_use;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= PARKED;
      cnt_q   <= '0;
      act_q   <= DIV_W'(DEFAULT_DIV);
      shd_q   <= DIV_W'(DEFAULT_DIV);
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    shd_d    = shd_q;
    pend_d   = pend_q;
    clk_d    = clk_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    parked   = (state_q == PARKED);
    // A parked channel starts on its pending divisor, which transfers this same cycle.
    div_use  = (parked && pend_q) ? shd_q : act_q;
    sync_hit = sync && en;
    count    = !sync_hit && (en || clk_q);
    tgl      = count && (cnt_q == div_use);
    xfer     = pend_q && (parked || tgl || sync_hit);

    if (sync_hit) begin
      cnt_d   = '0;
      clk_d   = 1'b0;
      fall_d  = clk_q;
      state_d = RUN;
    end else if (count) begin
      if (tgl) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        rise_d = ~clk_q;
        fall_d = clk_q;
      end else begin
        cnt_d  = cnt_q + 1'b1;
      end
      // Disabled while high: finish the high phase, park on the fall.
      if (en)       state_d = RUN;
      else if (tgl) state_d = PARKED;
      else          state_d = DRAIN;
    end else begin
      cnt_d   = '0;
      state_d = PARKED;
    end

    if (xfer) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    if (we) begin
      shd_d  = wdiv;
      pend_d = 1'b1;
    end
  end

  assign clk_out  = clk_q;
  assign rise_stb = rise_q;
  assign fall_stb = fall_q;
  assign pending  = pend_q;
endmodule

// File: rtl/gen_clk_bank.sv
// Bank of NUM_CH independent programmable 50%-duty clock dividers on CLOCK_50.
module gen_clk_bank
  import gen_clk_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          DIV_W       = 12,
  parameter int unsigned DEFAULT_DIV = GEN_CLK_DEFAULT_DIV
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  gen_clk_bank_if.slave bus
);
  localparam int CH_W = ch_w(NUM_CH);

  // Out-of-range channel selects match no instance and are dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic we_g;
    assign we_g = bus.cfg_we && (bus.cfg_ch == CH_W'(g));

    gen_clk_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .we       (we_g),
      .wdiv     (bus.cfg_div),
      .en       (bus.ch_en[g]),
      .sync     (bus.sync),
      .clk_out  (bus.clk_out[g]),
      .rise_stb (bus.rise_stb[g]),
      .fall_stb (bus.fall_stb[g]),
      .pending  (bus.pending[g])
    );
  end
endmodule
